// File: rtl/mux_arb_stage.sv
// N-channel arbitrated mux with a registered valid/ready output stage.
// Ports: clk, nreset, in_valid/in_data/in_ready, out_valid/out_data/out_sel/out_ready.
module mux_arb_stage #(
  parameter int N  = 5,
  parameter int DW = 32,
  parameter int RR = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [N-1:0]  in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [N-1:0]  out_sel,
  input  logic          out_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] start;
  logic [PW-1:0] kidx;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  grant;
  logic [DW-1:0] mux_data;
  logic          space;
  logic          load;

  assign start = (RR != 0) ? ptr : '0;

  // Cyclic search from start; first requester wins.
  always_comb begin
    int c;
    logic found;
    grant = '0;
    found = 1'b0;
    c = 0;
    for (int j = 0; j < N; j++) begin
      c = int'(start) + j;
      if (c >= N) c = c - N;
      if (!found && in_valid[PW'(c)]) begin
        grant[PW'(c)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    kidx = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) kidx = PW'(i);
  end

  assign ptr_nxt = (kidx == PW'(N - 1)) ? '0
                 : kidx + PW'(1);

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++)
      mux_data = mux_data
               | (in_data[i*DW +: DW] & {DW{grant[i]}});
  end

  // Reset gates the handshake so nothing is accepted while held.
  assign space    = (~out_valid | out_ready) & nreset;
  assign load     = space & (|in_valid);
  assign in_ready = grant & {N{space}};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= grant;
      if (RR != 0) ptr <= ptr_nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
    end
  end

endmodule
